// File: rtl/cache_backing_mem_pkg.sv
// Shared definitions for the cache backing-store stage: default geometry,
// FSM state encoding and a small width helper.
package cache_backing_mem_pkg;

  localparam int CBM_ADDR_W     = 4;
  localparam int CBM_DATA_W     = 8;
  localparam int CBM_LINE_WORDS = 2;
  localparam int CBM_LATENCY    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_WR,
    ST_DONE
  } cbm_state_e;

  // Width of a counter indexing n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_backing_mem_array.sv
// Line storage: 2**ADDR_W lines of LINE_WORDS words. One synchronous write
// port, one combinational read port, synchronous active-low clear.
module cache_backing_mem_array
  import cache_backing_mem_pkg::*;
#(
  parameter int ADDR_W     = CBM_ADDR_W,
  parameter int DATA_W     = CBM_DATA_W,
  parameter int LINE_WORDS = CBM_LINE_WORDS,
  parameter int BEAT_W     = idx_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_line_i,
  input  logic [BEAT_W-1:0] wr_beat_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_line_i,
  input  logic [BEAT_W-1:0] rd_beat_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = (2 ** ADDR_W) * LINE_WORDS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear the whole array on reset, otherwise commit one word per write.
  // NOTE: this storage is cleared by reset on purpose (the cache relies on
  // zeroed lines after reset); that forces flops rather than an SRAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[{wr_line_i, wr_beat_i}] <= wr_data_i;
    end
  end

  // Line/beat concatenation is a valid index because LINE_WORDS is a power of 2.
  assign rd_data_o = mem_q[{rd_line_i, rd_beat_i}];

endmodule

// File: rtl/cache_backing_mem.sv
// Backing-store stage below the cache controller: accepts one line request,
// waits LATENCY cycles, then streams a refill or absorbs a writeback burst.
module cache_backing_mem
  import cache_backing_mem_pkg::*;
#(
  parameter int ADDR_W     = CBM_ADDR_W,
  parameter int DATA_W     = CBM_DATA_W,
  parameter int LINE_WORDS = CBM_LINE_WORDS,
  parameter int LATENCY    = CBM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              busy
);

  localparam int BEAT_W = idx_w(LINE_WORDS);
  localparam int CNT_W  = idx_w(LATENCY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  cbm_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;
  logic              wr_ready_q;
  logic              done_q;
  logic              busy_q;

  logic              mem_we;
  logic [BEAT_W-1:0] rd_beat;
  logic [DATA_W-1:0] rd_data;

  // A read beat is fetched for the current beat when first presenting data,
  // and for the following beat when the current one is being accepted.
  assign rd_beat = (rsp_valid_q && rsp_ready) ? beat_q + BEAT_W'(1) : beat_q;
  assign mem_we  = (state_q == ST_WR) && wr_ready_q && wr_valid;

  cache_backing_mem_array #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .BEAT_W     (BEAT_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (mem_we),
    .wr_line_i (addr_q),
    .wr_beat_i (beat_q),
    .wr_data_i (wr_data),
    .rd_line_i (addr_q),
    .rd_beat_i (rd_beat),
    .rd_data_o (rd_data)
  );

  // Request FSM with latency counter, beat counter and registered outputs.
  // RD/WR spend their first cycle raising the registered handshake output, so
  // the first beat can move LATENCY+1 edges after the request was accepted.
  // NOTE: every register here uses <= so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= ST_WAIT;
            addr_q      <= req_addr;
            write_q     <= req_write;
            cnt_q       <= CNT_W'(LATENCY - 1);
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= write_q ? ST_WR : ST_RD;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        ST_RD: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_data;
            rsp_last_q  <= (rd_beat == LAST_BEAT);
          end else if (rsp_ready) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (rsp_last_q) begin
              state_q     <= ST_IDLE;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              rsp_data_q <= rd_data;
              rsp_last_q <= (rd_beat == LAST_BEAT);
            end
          end
        end
        ST_WR: begin
          if (!wr_ready_q) begin
            wr_ready_q <= 1'b1;
          end else if (wr_valid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              state_q    <= ST_DONE;
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_ready  = wr_ready_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cache_backing_mem.sv
// Self-checking bench for cache_backing_mem: a transaction-level timing model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_cache_backing_mem;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LW     = 2;
  localparam int LAT    = 3;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  cache_backing_mem #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LINE_WORDS (LW), .LATENCY (LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write), .req_addr (req_addr),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data), .rsp_last (rsp_last),
    .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data),
    .done (done), .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One transaction at a time. A request accepted at edge E makes its data
  // channel live from edge E+LAT+1 on; a finished writeback shows done for the
  // single cycle after its last beat.
  logic [DATA_W-1:0] m_mem [(2**ADDR_W)*LW];
  bit armed    = 1'b0;
  bit m_active = 1'b0;
  bit m_write  = 1'b0;
  bit m_done   = 1'b0;
  int m_addr   = 0;
  int m_beat   = 0;
  int m_acc    = 0;
  int cyc      = 0;

  function automatic bit e_busy();
    return m_active || m_done;
  endfunction
  function automatic bit e_live();
    return m_active && (cyc >= m_acc + LAT + 1);
  endfunction
  function automatic bit e_rsp_valid();
    return e_live() && !m_write;
  endfunction
  function automatic bit e_wr_ready();
    return e_live() && m_write;
  endfunction

  always @(posedge clk) begin
    bit idle, rv, wv;
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_beat   = 0;
      armed    = 1'b1;
    end else if (armed) begin
      idle   = !e_busy();
      rv     = e_rsp_valid();
      wv     = e_wr_ready();
      m_done = 1'b0;
      if (idle && req_valid) begin
        m_active = 1'b1;
        m_write  = req_write;
        m_addr   = int'(req_addr);
        m_beat   = 0;
        m_acc    = cyc + 1;
      end else if (rv && rsp_ready) begin
        m_beat++;
        if (m_beat == LW) begin
          m_active = 1'b0;
          m_beat   = 0;
        end
      end else if (wv && wr_valid) begin
        m_mem[m_addr*LW + m_beat] = wr_data;
        m_beat++;
        if (m_beat == LW) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_beat   = 0;
        end
      end
    end
    cyc++;
  end

  // Compare all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("req_ready", req_ready, !e_busy());
      check("busy",      busy,      e_busy());
      check("rsp_valid", rsp_valid, e_rsp_valid());
      check("wr_ready",  wr_ready,  e_wr_ready());
      check("done",      done,      m_done);
      if (e_rsp_valid()) begin
        check("rsp_data", rsp_data, m_mem[m_addr*LW + m_beat]);
        check("rsp_last", rsp_last, m_beat == LW - 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 40) begin
      step();
      t++;
    end
    check("idle_timeout", req_ready, 1'b1);
  endtask

  task automatic write_line(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1, input bit rnd, output int lat);
    int b = 0;
    bit hs;
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = ADDR_W'($urandom);
    wr_valid  = !rnd; wr_data = d0;
    lat = 0;
    while (!wr_ready && lat < 20) begin
      if (rnd) begin
        wr_valid  = 1'($urandom);
        req_valid = 1'($urandom);
      end
      step();
      lat++;
    end
    for (int t = 0; t < 60 && b < LW; t++) begin
      wr_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_data  = (b == 0) ? d0 : d1;
      if (rnd) req_valid = 1'($urandom);
      hs = wr_valid && wr_ready;
      step();
      if (hs) b++;
    end
    wr_valid = 1'b0; req_valid = 1'b0;
    check("wr_beats", b, LW);
    check("wb_done_pulse", done, 1'b1);
    check("wb_done_busy", busy, 1'b1);
    step();
    check("wb_done_clear", done, 1'b0);
    check("wb_idle", busy, 1'b0);
  endtask

  task automatic read_line(input logic [ADDR_W-1:0] a, input int hold0, input logic [DATA_W-1:0] hold_exp,
                           input bit rnd, input bit poke,
                           output logic [2*DATA_W-1:0] data, output logic [LW-1:0] lasts, output int lat);
    int b = 0;
    bit hs;
    data = '0; lasts = '0;
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = ADDR_W'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      rsp_ready = rnd ? 1'($urandom) : (hold0 == 0);
      if (poke) begin
        req_valid = 1'b1; req_addr = 4'd2; req_write = 1'b1;
        check("busy_reject", req_ready, 1'b0);
      end else if (rnd) begin
        req_valid = 1'($urandom);
      end
      step();
      lat++;
    end
    req_valid = 1'b0;
    for (int t = 0; t < 60 && b < LW; t++) begin
      rsp_ready = (t < hold0) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (t < hold0) check("bp_hold_data", rsp_data, hold_exp);
      if (rnd) req_valid = 1'($urandom);
      hs = rsp_ready && rsp_valid;
      if (hs) begin
        data[b*DATA_W +: DATA_W] = rsp_data;
        lasts[b] = rsp_last;
      end
      step();
      if (hs) b++;
    end
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("rd_beats", b, LW);
    check("rd_idle", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [2*DATA_W-1:0] rd;
    logic [LW-1:0]       ls;
    int                  lat;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    rsp_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    rst_n = 1'b1;

    read_line(4'd5, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("rst_line5", rd, 16'h0000);

    write_line(4'd2, 8'h11, 8'h22, 1'b0, lat);
    write_line(4'd5, 8'hA5, 8'h3C, 1'b0, lat);
    check("wb_latency", lat, LAT + 1);
    check("model_line5_b0", m_mem[10], 8'hA5);
    check("model_line5_b1", m_mem[11], 8'h3C);

    read_line(4'd5, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("rd_latency", lat, LAT + 1);
    check("rd_data", rd, 16'h3CA5);
    check("rd_last", ls, 2'b10);

    read_line(4'd5, 4, 8'hA5, 1'b0, 1'b0, rd, ls, lat);
    check("bp_data", rd, 16'h3CA5);
    check("bp_last", ls, 2'b10);

    read_line(4'd5, 0, 8'h00, 1'b0, 1'b1, rd, ls, lat);
    check("poke_rd_data", rd, 16'h3CA5);
    read_line(4'd2, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("line2_intact", rd, 16'h2211);

    write_line(4'd9, 8'hC3, 8'h7E, 1'b0, lat);
    read_line(4'd9, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("raw_after_done", rd, 16'h7EC3);

    // Reset in the middle of a writeback burst.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7;
    step();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h5A;
    lat = 0;
    while (!wr_ready && lat < 20) begin
      step();
      lat++;
    end
    check("mb_wr_ready", wr_ready, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    check("mb_wr_ready_low", wr_ready, 1'b0);
    check("mb_busy", busy, 1'b0);
    check("mb_req_ready", req_ready, 1'b1);
    rst_n = 1'b1; wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mb_no_done", done, 1'b0);
    end
    read_line(4'd7, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("mb_line7_clear", rd, 16'h0000);
    read_line(4'd5, 0, 8'h00, 1'b0, 1'b0, rd, ls, lat);
    check("mb_line5_clear", rd, 16'h0000);

    // Randomized traffic with gaps, backpressure and ignored requests.
    for (int i = 0; i < 80; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        write_line(a, DATA_W'($urandom), DATA_W'($urandom), 1'b1, lat);
      else
        read_line(a, int'($urandom_range(0, 2)), m_mem[int'(a)*LW], 1'b1, 1'b0, rd, ls, lat);
      rsp_ready = 1'($urandom); wr_valid = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
      rsp_ready = 1'b0; wr_valid = 1'b0;
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
